// File: rtl/cla_pkg.sv
// Shared constants and lookahead carry function for the pipelined CLA.
// Latency: none (package only).
// Backpressure: not applicable.
package cla_pkg;

  // Default bits per lookahead group.
  localparam int CLA_GROUP = 4;

  // Widest group the carry function supports; narrower groups zero-pad g/p.
  localparam int CLA_MAXG = 16;

  // Flat sum-of-products lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  // Every carry is built from g/p/cin directly, so no carry depends on another.
  function automatic logic [CLA_MAXG:0] cla_carries(
    input logic [CLA_MAXG-1:0] g,
    input logic [CLA_MAXG-1:0] p,
    input logic                cin
  );
    logic [CLA_MAXG:0] c;
    logic              t;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CLA_MAXG; i++) begin
      t = cin;
      for (int m = 0; m <= i; m++) t = t & p[m];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: sum bits, carry out, group generate/propagate.
// Latency: combinational.
// Backpressure: none (pure datapath).
// Ports: a, b (GROUP operand bits), cin -> sum, cout, g (group generate), p (group propagate).
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             g,
  output logic             p
);

  logic [CLA_MAXG-1:0] gx;
  logic [CLA_MAXG-1:0] px;
  logic [CLA_MAXG:0]   cv;
  logic [CLA_MAXG:0]   gv;
  logic                unused_hi;

  always_comb begin
    gx             = '0;
    px             = '0;
    gx[GROUP-1:0]  = a & b;
    px[GROUP-1:0]  = a ^ b;
  end

  assign cv   = cla_carries(gx, px, cin);
  // Group generate is the carry out with a zero carry in.
  assign gv   = cla_carries(gx, px, 1'b0);

  assign sum  = px[GROUP-1:0] ^ cv[GROUP-1:0];
  assign cout = cv[GROUP];
  assign g    = gv[GROUP];
  assign p    = &px[GROUP-1:0];

  // Carries above the group width are zero padding.
  assign unused_hi = ^{cv, gv};

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit group resolved per stage.
// Latency: NSTG = WIDTH/GROUP cycles accept-to-out_valid, one result per cycle.
// Backpressure: stall = out_valid & ~out_ready freezes every stage; in_ready = ~stall.
// Ports: clk, rst (async high); in_valid/in_ready, a, b, cin, sub;
//        out_valid/out_ready, sum, cout (1 = no borrow on sub), ovf (signed overflow).
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / GROUP;

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO  = k * GROUP;
    // Operand bits above this group, carried forward to later stages.
    localparam int REM = WIDTH - LO - GROUP;

    logic                vi, ci;
    logic [GROUP-1:0]    ai, bi, gs;
    logic                gc, gg, gp;
    logic [LO+GROUP-1:0] s_d, s_q;
    logic                vld_q, c_q;

    if (k == 0) begin : g_src
      assign vi  = in_valid;
      assign ci  = c0;
      assign ai  = a[GROUP-1:0];
      assign bi  = b_eff[GROUP-1:0];
      assign s_d = gs;
    end else begin : g_src
      assign vi  = g_stg[k-1].vld_q;
      assign ci  = g_stg[k-1].c_q;
      assign ai  = g_stg[k-1].g_rem.a_q[GROUP-1:0];
      assign bi  = g_stg[k-1].g_rem.b_q[GROUP-1:0];
      assign s_d = {gs, g_stg[k-1].s_q};
    end

    cla_group #(.GROUP(GROUP)) u_grp (
      .a    (ai),
      .b    (bi),
      .cin  (ci),
      .sum  (gs),
      .cout (gc),
      .g    (gg),
      .p    (gp)
    );

    // Bubbles advance too; only a stall holds the registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (!stall) begin
        vld_q <= vi;
        c_q   <= gc;
        s_q   <= s_d;
      end
    end

    if (REM > 0) begin : g_rem
      // Operands stay right-aligned: the next group is always the low GROUP bits.
      logic [REM-1:0] a_q, b_q, a_d, b_d;
      if (k == 0) begin : g_up
        assign a_d = a[WIDTH-1:GROUP];
        assign b_d = b_eff[WIDTH-1:GROUP];
      end else begin : g_up
        assign a_d = g_stg[k-1].g_rem.a_q[REM+GROUP-1:GROUP];
        assign b_d = g_stg[k-1].g_rem.b_q[REM+GROUP-1:GROUP];
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      // The last group holds the sign bits of a and b_eff.
      logic ovf_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= (ai[GROUP-1] == bi[GROUP-1]) & (gs[GROUP-1] != ai[GROUP-1]);
        end
      end
    end

    // The flat lookahead carry must agree with the group G/P form.
    a_gp_consistent : assert property (@(posedge clk) disable iff (rst)
      gc == (gg | (gp & ci)));
  end

  assign out_valid = g_stg[NSTG-1].vld_q;
  assign sum       = g_stg[NSTG-1].s_q;
  assign cout      = g_stg[NSTG-1].c_q;
  assign ovf       = g_stg[NSTG-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference result {ovf, cout, sum} straight from the arithmetic definition.
  function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
    logic [W-1:0] ye;
    logic [W:0]   r;
    logic         v;
    ye = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s | c)};
    v  = (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]);
    return {v, r};
  endfunction

  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is);
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
  endtask

  // Counts negedges from the accept cycle until out_valid; -1 on timeout.
  task automatic await_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset sum got %h want 0000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset cout got %b want 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf got %b want 0", ovf); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    logic [W-1:0] va [2] = '{16'h00FF, 16'hFFFF};
    logic [W-1:0] vb [2] = '{16'h0001, 16'h0000};
    logic         vc [2] = '{1'b0, 1'b1};
    logic [W-1:0] es [2] = '{16'h0100, 16'h0000};
    logic         ec [2] = '{1'b0, 1'b1};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      launch(va[i], vb[i], vc[i], 1'b0);
      await_result(lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL add[%0d] latency got %0d want 4", i, lat); end
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL add[%0d] sum got %h want %h", i, sum, es[i]); end
      checks++; if (cout !== ec[i]) begin errors++; $display("FAIL add[%0d] cout got %b want %b", i, cout, ec[i]); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add[%0d] ovf got %b want 0", i, ovf); end
    end
  endtask

  task automatic test_subtract();
    // Third vector: cin must be ignored while sub=1.
    logic [W-1:0] va [3] = '{16'h0005, 16'h8000, 16'h0005};
    logic [W-1:0] vb [3] = '{16'h0007, 16'h0001, 16'h0007};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [3] = '{16'hFFFE, 16'h7FFF, 16'hFFFE};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    logic         eo [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], vc[i], 1'b1);
      await_result(lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL sub[%0d] latency got %0d want 4", i, lat); end
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL sub[%0d] sum got %h want %h", i, sum, es[i]); end
      checks++; if (cout !== ec[i]) begin errors++; $display("FAIL sub[%0d] cout got %b want %b", i, cout, ec[i]); end
      checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL sub[%0d] ovf got %b want %b", i, ovf, eo[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] va [2] = '{16'h7FFF, 16'h8000};
    logic [W-1:0] vb [2] = '{16'h0001, 16'h8000};
    logic [W-1:0] es [2] = '{16'h8000, 16'h0000};
    logic         ec [2] = '{1'b0, 1'b1};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      launch(va[i], vb[i], 1'b0, 1'b0);
      await_result(lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL ovf[%0d] latency got %0d want 4", i, lat); end
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL ovf[%0d] sum got %h want %h", i, sum, es[i]); end
      checks++; if (cout !== ec[i]) begin errors++; $display("FAIL ovf[%0d] cout got %b want %b", i, cout, ec[i]); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf[%0d] ovf got %b want 1", i, ovf); end
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vc [8];
    logic         vs [8];
    logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [W+1:0] exq [$];
    logic [W+1:0] exp_v;
    int idx = 0, got = 0, cyc = 0;
    for (int i = 0; i < 8; i++) begin
      va[i] = W'($urandom);
      vb[i] = W'($urandom);
      vc[i] = 1'($urandom);
      vs[i] = 1'($urandom);
    end
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (idx < 8);
      if (idx < 8) begin a = va[idx]; b = vb[idx]; cin = vc[idx]; sub = vs[idx]; end
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL stream in_ready cyc %0d got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (in_valid && in_ready) begin
        exq.push_back(golden(va[idx], vb[idx], vc[idx], vs[idx]));
        idx++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exq.size() == 0) begin
          errors++; $display("FAIL stream unexpected beat got %h want none", {ovf, cout, sum});
        end else begin
          exp_v = exq.pop_front();
          if ({ovf, cout, sum} !== exp_v) begin
            errors++; $display("FAIL stream beat %0d {ovf,cout,sum} got %h want %h", got, {ovf, cout, sum}, exp_v);
          end
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (got != 8) begin errors++; $display("FAIL stream delivered got %0d want 8", got); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [6] = '{16'h0001, 16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hAAAA};
    logic [W-1:0] vb [6] = '{16'h0001, 16'h4321, 16'h0001, 16'h7FFF, 16'hF0F0, 16'h5555};
    logic [W+1:0] exq [$];
    int           acq [$];
    logic [W+1:0] exp_v;
    int idx = 0, got = 0, cyc = 0, acc_cyc;
    out_ready = 1'b1;
    while (got < 6 && cyc < 100) begin
      @(negedge clk);
      in_valid = (idx < 6);
      if (idx < 6) begin a = va[idx]; b = vb[idx]; cin = 1'b0; sub = 1'b0; end
      #1;
      if (in_valid && in_ready) begin
        exq.push_back(golden(va[idx], vb[idx], 1'b0, 1'b0));
        acq.push_back(cyc);
        idx++;
      end
      if (out_valid) begin
        checks++;
        if (exq.size() == 0) begin
          errors++; $display("FAIL b2b unexpected beat got %h want none", {ovf, cout, sum});
        end else begin
          exp_v = exq.pop_front();
          acc_cyc = acq.pop_front();
          if ({ovf, cout, sum} !== exp_v) begin
            errors++; $display("FAIL b2b beat %0d {ovf,cout,sum} got %h want %h", got, {ovf, cout, sum}, exp_v);
          end
          checks++;
          if (cyc != got + 4 || acc_cyc != got) begin
            errors++; $display("FAIL b2b timing beat %0d out cyc %0d acc cyc %0d want %0d and %0d", got, cyc, acc_cyc, got + 4, got);
          end
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 6) begin errors++; $display("FAIL b2b delivered got %0d want 6", got); end
  endtask

  task automatic test_reset_flush();
    logic [W-1:0] va [3] = '{16'h0011, 16'h0022, 16'h0033};
    int stale = 0;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i]; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush pre-reset out_valid got %b want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush async out_valid got %b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL flush stale beats got %0d want 0", stale); end
    launch(16'h1234, 16'h1111, 1'b0, 1'b0);
    await_result(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL flush latency got %0d want 4", lat); end
    checks++; if (sum !== 16'h2345) begin errors++; $display("FAIL flush sum got %h want 2345", sum); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract();
    test_overflow();
    test_stream();
    test_back_to_back();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface on both sides. The operand is split into GROUP-bit lookahead groups. Each pipeline stage resolves one group with a full 4-level lookahead and registers the group carry into the next stage. The block is the datapath adder for the wider arithmetic units and replaces single-cycle 4-bit CLA instances where width and timing demand pipelining.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP and at least GROUP.
GROUP, 4, bits per lookahead group; the pipeline has one stage per group.
NSTG, WIDTH/GROUP, derived stage count and latency in cycles; localparam, not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in; ignored when sub=1
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  result
cout  output  1  carry out of the MSB; for sub, 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: one clock `clk`. Reset `rst` is asynchronous and active-high. It clears every stage valid bit; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the first cycle after reset deasserts.
- Accept: a beat is accepted when in_valid & in_ready. Delivery happens when out_valid & out_ready.
- Stall: global stall = out_valid & ~out_ready. in_ready = ~stall. When stalled, all stage registers hold, including bubbles.
- Bubbles: when not stalled, every stage advances every cycle. Bubbles do advance, so they collapse only at the output.
- Stage 0 inputs: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..NSTG-1):
  - Computes g/p for group k, the intra-group carries by lookahead (no ripple), sum bits [k*GROUP +: GROUP], and the group carry-out.
  - Registers the group carry-out, sum bits produced so far, remaining upper a/b_eff bits, sign bits for overflow, and valid.
- Latency: exactly NSTG cycles from accept to out_valid with no stall. Back-to-back acceptance gives one result per cycle.
- Outputs are registered and driven from the final stage.
  - cout = carry out of bit WIDTH-1.
  - ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]).
- Ordering: results leave in acceptance order. No beat is dropped or duplicated under any out_ready pattern.
- Simultaneous accept and deliver in the same cycle is legal; the pipeline shifts by one.
- Wrap-around: sum is modulo 2^WIDTH; the carry appears only on cout.
- Sum, cout and ovf are don't-care when out_valid=0, apart from their reset values.
- Reset mid-operation flushes all in-flight beats; none are delivered after reset.
- in_ready is combinational from out_ready. This is the only input-to-output combinational path.

Decomposition:
- Package cla_pkg: default GROUP constant, and a function computing the group lookahead carry vector from (g, p, cin) for a GROUP-bit group.
- Sub-module cla_group (combinational, parameter GROUP):
  - inputs a, b, cin; outputs sum, cout, group G and P.
  - instantiated once per stage in a generate loop.
- The top-level holds the stage registers and the handshake logic only.

Test Plan:
- Reset, then a=16'h00FF, b=16'h0001, cin=0, sub=0 for one beat, out_ready=1 → out_valid exactly 4 cycles later; sum=16'h0100, cout=0, ovf=0. This exercises carry across group boundaries.
- a=16'hFFFF, b=16'h0000, cin=1 → sum=16'h0000, cout=1, ovf=0. Full-width carry chain through all stages.
- sub=1: a=16'h0005, b=16'h0007 → sum=16'hFFFE, cout=0. Then a=16'h8000, b=16'h0001 → sum=16'h7FFF, ovf=1.
- Stream 8 random beats back-to-back with out_ready toggling 1,0,0,1,…:
  - outputs match a golden model in order;
  - in_ready=0 exactly when out_valid=1 and out_ready=0;
  - throughput is 1/cycle when out_ready is held high.
- a=16'h7FFF, b=16'h0001, sub=0 → sum=16'h8000, ovf=1, cout=0. Then a=16'h8000, b=16'h8000 → sum=0, cout=1, ovf=1.
- Accept 3 beats, assert rst for one cycle asynchronously mid-flight → out_valid drops immediately. No stale beat appears afterwards, and the next accepted beat emerges after 4 cycles.
